// File: rtl/fsmd_pkg.sv
// Shared types for the sum-of-products FSM+D unit.
//   state_e   : control FSM states (encoding is visible on the PS debug port)
//   mode_e    : expression select codes
//   reg_sel_e : per-register input mux select (hold / load / add / multiply)
//   dp_ctrl_t : control bundle from the FSM to the datapath
package fsmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP1  = 3'd1,
    S_OP2  = 3'd2,
    S_OP3  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_SUM3_MUL = 2'd0,  // (a+b+c)*e
    MODE_SUM_PROD = 2'd1,  // (a+c)*(c+d)
    MODE_DOT2     = 2'd2,  // a*b + c*d
    MODE_RSVD     = 2'd3   // y=0, err=1
  } mode_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_LOAD = 2'd1,
    SEL_ADD  = 2'd2,
    SEL_MUL  = 2'd3
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e r1_sel;
    reg_sel_e r2_sel;
    reg_sel_e r3_sel;
    logic     add_b_r3;  // adder second operand: 0=R2, 1=R3
    logic     mul_a_r2;  // multiplier first operand: 0=R1, 1=R2
    logic     mul_b_r3;  // multiplier second operand: 0=R2, 1=R3
  } dp_ctrl_t;

endpackage

// File: rtl/fsmd_sop_datapath.sv
// Datapath for fsmd_sop_unit: working registers R1..R3, their input muxes,
// one shared adder and one shared multiplier.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   ctrl_i           : mux selects and operand selects from the FSM
//   r1_ld_i..r3_ld_i : values loaded when a register's select is SEL_LOAD
//   r1_next_o        : value R1 takes at the coming edge (feeds the y register)
module fsmd_sop_datapath
  import fsmd_pkg::*;
#(
  parameter int unsigned RW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  dp_ctrl_t      ctrl_i,
  input  logic [RW-1:0] r1_ld_i,
  input  logic [RW-1:0] r2_ld_i,
  input  logic [RW-1:0] r3_ld_i,
  output logic [RW-1:0] r1_next_o
);

  logic [RW-1:0] r1_q, r2_q, r3_q;
  logic [RW-1:0] r1_d, r2_d, r3_d;
  logic [RW-1:0] add_b, sum, sum23;
  logic [RW-1:0] mul_a, mul_b, prod;

  // Shared adder R1 + (R2|R3); R2+R3 is a side sum needed only when R1 and
  // R2 both accumulate in the same cycle (mode 1, OP1).
  assign add_b = ctrl_i.add_b_r3 ? r3_q : r2_q;
  assign sum   = r1_q + add_b;
  assign sum23 = r2_q + r3_q;

  // Shared multiplier; product truncated to RW bits.
  assign mul_a = ctrl_i.mul_a_r2 ? r2_q : r1_q;
  assign mul_b = ctrl_i.mul_b_r3 ? r3_q : r2_q;
  assign prod  = mul_a * mul_b;

  // Register input muxes.
  always_comb begin
    r1_d = r1_q;
    r2_d = r2_q;
    r3_d = r3_q;
    case (ctrl_i.r1_sel)
      SEL_LOAD: r1_d = r1_ld_i;
      SEL_ADD:  r1_d = sum;
      SEL_MUL:  r1_d = prod;
      default:  r1_d = r1_q;
    endcase
    case (ctrl_i.r2_sel)
      SEL_LOAD: r2_d = r2_ld_i;
      SEL_ADD:  r2_d = sum23;
      SEL_MUL:  r2_d = prod;
      default:  r2_d = r2_q;
    endcase
    case (ctrl_i.r3_sel)
      SEL_LOAD: r3_d = r3_ld_i;
      SEL_MUL:  r3_d = prod;
      default:  r3_d = r3_q;
    endcase
  end

  // Working registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
    end else begin
      r1_q <= r1_d;
      r2_q <= r2_d;
      r3_q <= r3_d;
    end
  end

  assign r1_next_o = r1_d;

endmodule

// File: rtl/fsmd_sop_unit.sv
// Width-generic FSM+D sum-of-products engine. A fixed IDLE->OP1->OP2->OP3->DONE
// schedule drives three working registers, one adder and one multiplier.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : request (sampled in IDLE only); mode/a..e captured with it
//   y            : result, valid with done, held until the next accepted start
//   busy         : state is not IDLE
//   done         : one-cycle result pulse
//   err          : reserved mode (3) flagged alongside done
//   PS           : present state (debug)
module fsmd_sop_unit
  import fsmd_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic [WIDTH-1:0]     d,
  input  logic [WIDTH-1:0]     e,
  output logic [2*WIDTH+1:0]   y,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2:0]           PS
);

  localparam int unsigned RW = 2 * WIDTH + 2;

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [RW-1:0] d_q, d_d, e_q, e_d;   // operands consumed after the load cycle
  logic [RW-1:0] y_q, y_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  dp_ctrl_t      ctrl;
  logic [RW-1:0] r1_ld, r2_ld, r3_ld;
  logic [RW-1:0] r1_next;

  fsmd_sop_datapath #(.RW(RW)) u_dp (
    .clk_i     (clock),
    .rst_i     (reset),
    .ctrl_i    (ctrl),
    .r1_ld_i   (r1_ld),
    .r2_ld_i   (r2_ld),
    .r3_ld_i   (r3_ld),
    .r1_next_o (r1_next)
  );

  // Next state, datapath control and output register inputs.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    d_d           = d_q;
    e_d           = e_q;
    y_d           = y_q;
    err_d         = err_q;
    ctrl.r1_sel   = SEL_HOLD;
    ctrl.r2_sel   = SEL_HOLD;
    ctrl.r3_sel   = SEL_HOLD;
    ctrl.add_b_r3 = 1'b0;
    ctrl.mul_a_r2 = 1'b0;
    ctrl.mul_b_r3 = 1'b0;
    r1_ld         = '0;
    r2_ld         = '0;
    r3_ld         = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_OP1;
          mode_d      = mode_e'(mode);
          d_d         = RW'(d);
          e_d         = RW'(e);
          y_d         = '0;
          err_d       = 1'b0;
          ctrl.r1_sel = SEL_LOAD;
          ctrl.r2_sel = SEL_LOAD;
          ctrl.r3_sel = SEL_LOAD;
          case (mode_e'(mode))
            MODE_SUM3_MUL: begin r1_ld = RW'(a); r2_ld = RW'(c); r3_ld = RW'(b); end
            MODE_SUM_PROD: begin r1_ld = RW'(a); r2_ld = RW'(c); r3_ld = RW'(d); end
            MODE_DOT2:     begin r1_ld = RW'(a); r2_ld = RW'(b); r3_ld = RW'(c); end
            default:       begin r1_ld = '0;     r2_ld = '0;     r3_ld = '0;     end
          endcase
        end
      end

      S_OP1: begin
        state_d = S_OP2;
        case (mode_q)
          MODE_SUM3_MUL: ctrl.r1_sel = SEL_ADD;            // R1 = a+c
          MODE_SUM_PROD: begin                             // R1 = a+c, R2 = c+d
            ctrl.r1_sel = SEL_ADD;
            ctrl.r2_sel = SEL_ADD;
          end
          MODE_DOT2: begin                                 // R1 = a*b, R2 = d
            ctrl.r1_sel = SEL_MUL;
            ctrl.r2_sel = SEL_LOAD;
            r2_ld       = d_q;
          end
          default: ;
        endcase
      end

      S_OP2: begin
        state_d = S_OP3;
        case (mode_q)
          MODE_SUM3_MUL: begin                             // R1 += b, R3 = e
            ctrl.r1_sel   = SEL_ADD;
            ctrl.add_b_r3 = 1'b1;
            ctrl.r3_sel   = SEL_LOAD;
            r3_ld         = e_q;
          end
          MODE_SUM_PROD: ctrl.r1_sel = SEL_MUL;            // R1 = R1*R2
          MODE_DOT2: begin                                 // R2 = d*c
            ctrl.r2_sel   = SEL_MUL;
            ctrl.mul_a_r2 = 1'b1;
            ctrl.mul_b_r3 = 1'b1;
          end
          default: ;
        endcase
      end

      S_OP3: begin
        state_d = S_DONE;
        case (mode_q)
          MODE_SUM3_MUL: begin                             // R1 = R1*e
            ctrl.r1_sel   = SEL_MUL;
            ctrl.mul_b_r3 = 1'b1;
          end
          MODE_DOT2: ctrl.r1_sel = SEL_ADD;                // R1 = ab + cd
          default: ;
        endcase
        // y captures R1 after this cycle's operation, not the stale R1.
        y_d   = r1_next;
        err_d = (mode_q == MODE_RSVD);
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Control and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_SUM3_MUL;
      d_q     <= '0;
      e_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      d_q     <= d_d;
      e_q     <= e_d;
      y_q     <= y_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign y    = y_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign done = done_q;
  assign PS   = state_q;

endmodule

// File: tb/tb_fsmd_sop_unit.sv
// Self-checking bench for fsmd_sop_unit (WIDTH=4): directed cases plus
// randomized runs checked against an arithmetic reference model.
module tb_fsmd_sop_unit;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned RW    = 2 * WIDTH + 2;

  logic             clock;
  logic             reset;
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a, b, c, d, e;
  logic [RW-1:0]    y;
  logic             busy, done, err;
  logic [2:0]       PS;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_accept = -1;

  fsmd_sop_unit #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .PS    (PS)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: the expressions themselves, reduced to RW bits.
  function automatic int model(input int m, input int av, input int bv,
                               input int cv, input int dv, input int ev);
    int r;
    case (m)
      0:       r = (av + bv + cv) * ev;
      1:       r = (av + cv) * (cv + dv);
      2:       r = av * bv + cv * dv;
      default: r = 0;
    endcase
    return r % (1 << RW);
  endfunction

  task automatic scramble_inputs();
    mode = 2'($urandom_range(0, 3));
    a = WIDTH'($urandom_range(0, 15));
    b = WIDTH'($urandom_range(0, 15));
    c = WIDTH'($urandom_range(0, 15));
    d = WIDTH'($urandom_range(0, 15));
    e = WIDTH'($urandom_range(0, 15));
  endtask

  // One full transaction; when hold=1 start stays high with junk operands.
  task automatic run_op(input int m, input int av, input int bv, input int cv,
                        input int dv, input int ev, input bit hold);
    int expv;
    int t;
    expv = model(m, av, bv, cv, dv, ev);
    t = 0;
    while (PS !== 3'd0 && t < 10) begin
      @(negedge clock);
      t++;
    end
    check_eq("idle_wait", int'(PS), 0);
    mode = 2'(m); a = WIDTH'(av); b = WIDTH'(bv); c = WIDTH'(cv);
    d = WIDTH'(dv); e = WIDTH'(ev);
    start = 1'b1;
    @(negedge clock);
    if (hold && last_accept >= 0) check_eq("accept_period", cyc - last_accept, 5);
    last_accept = cyc;
    check_eq("op1_ps", int'(PS), 1);
    check_eq("op1_busy", int'(busy), 1);
    check_eq("op1_done", int'(done), 0);
    check_eq("accept_y_clr", int'(y), 0);
    check_eq("accept_err_clr", int'(err), 0);
    start = hold;
    scramble_inputs();
    for (int k = 2; k <= 3; k++) begin
      @(negedge clock);
      check_eq("op_ps", int'(PS), k);
      check_eq("op_busy", int'(busy), 1);
      check_eq("op_done", int'(done), 0);
      check_eq("op_y_zero", int'(y), 0);
      scramble_inputs();
    end
    @(negedge clock);
    check_eq("done_ps", int'(PS), 4);
    check_eq("done_pulse", int'(done), 1);
    check_eq("done_busy", int'(busy), 1);
    check_eq("done_y", int'(y), expv);
    check_eq("done_err", int'(err), (m == 3) ? 1 : 0);
    @(negedge clock);
    check_eq("idle_ps", int'(PS), 0);
    check_eq("idle_busy", int'(busy), 0);
    check_eq("idle_done", int'(done), 0);
    check_eq("idle_y_hold", int'(y), expv);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mode  = '0;
    a = '0; b = '0; c = '0; d = '0; e = '0;
    repeat (2) @(negedge clock);
    check_eq("rst_ps", int'(PS), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_y", int'(y), 0);
    reset = 1'b0;
    @(negedge clock);

    // Directed cases.
    run_op(0, 3, 5, 2, 0, 7, 1'b0);          // 70
    run_op(1, 15, 0, 15, 15, 0, 1'b0);       // 900, widest result
    run_op(2, 15, 15, 15, 15, 0, 1'b0);      // 450
    run_op(2, 2, 3, 4, 5, 0, 1'b0);          // 26

    // Start held high: back-to-back accepts every 5 cycles.
    last_accept = -1;
    run_op(0, 1, 2, 3, 0, 4, 1'b1);
    run_op(1, 7, 0, 9, 11, 0, 1'b1);
    run_op(2, 6, 7, 8, 9, 0, 1'b1);
    start = 1'b0;
    @(negedge clock);

    // Reset in OP2 aborts with no done pulse.
    mode = 2'd0; a = 4'd9; b = 4'd9; c = 4'd9; e = 4'd9;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check_eq("pre_rst_ps", int'(PS), 2);
    reset = 1'b1;
    @(negedge clock);
    check_eq("abort_ps", int'(PS), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_y", int'(y), 0);
    check_eq("abort_done", int'(done), 0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check_eq("abort_no_done", int'(done), 0);
    end
    run_op(2, 2, 3, 4, 5, 0, 1'b0);

    // Reserved mode, then a normal run clears err.
    run_op(3, 13, 12, 11, 10, 9, 1'b0);
    run_op(0, 4, 4, 4, 0, 4, 1'b0);

    // Randomized runs.
    for (int n = 0; n < 30; n++) begin
      int m;
      m = int'($urandom_range(0, 3));
      run_op(m, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsmd_sop_unit.md
# fsmd_sop_unit

Parametrised FSM+D arithmetic unit that evaluates one of three sum-of-products expressions on five unsigned operands. It uses three working registers, one adder and one multiplier, sequenced by a control FSM over a fixed four-cycle schedule. It adds a start/busy/done handshake, operand capture and a mode select. It sits beside the existing single-expression control units as the reusable, width-generic arithmetic engine.

## Interface

- Parameter `WIDTH` = 4: operand width in bits.
- Derived constant `RW` = 2*WIDTH+2: width of the working registers and of the result.
- Clock and reset:
  - `clock` in 1: rising-edge clock.
  - `reset` in 1: synchronous, active-high reset.
- Handshake and operands:
  - `start` in 1: request a computation. Sampled only in IDLE.
  - `mode` in 2: expression select, captured with `start`.
  - `a`, `b`, `c`, `d`, `e` in WIDTH each: unsigned operands, captured with `start`.
- Results and status:
  - `y` out RW: result; valid while `done`=1 and held until the next accepted start.
  - `busy` out 1: 1 whenever the state is not IDLE.
  - `done` out 1: one-cycle pulse marking a valid result.
  - `err` out 1: asserted together with `done` when `mode`=3.
  - `PS` out 3: present state, for debug.

## Operation

- Modes:
  - 0: y = (a+b+c)*e
  - 1: y = (a+c)*(c+d)
  - 2: y = a*b + c*d
  - 3: reserved; produces y=0 and err=1.
- States, in fixed order: IDLE → OP1 → OP2 → OP3 → DONE → IDLE. There is no data-dependent branching.
- Operand capture: operands are zero-extended to RW. Registers R1..R3 load at the edge where `start` is accepted in IDLE; the mode is latched at the same edge.
- Register transfers per mode:
  - Mode 0:
    - load: R1←a, R2←c, R3←b
    - OP1: R1←R1+R2
    - OP2: R1←R1+R3, R3←e
    - OP3: R1←R1*R3
  - Mode 1:
    - load: R1←a, R2←c, R3←d
    - OP1: R1←R1+R2, R2←R2+R3
    - OP2: R1←R1*R2
    - OP3: no operation
  - Mode 2:
    - load: R1←a, R2←b, R3←c
    - OP1: R1←R1*R2, R2←d
    - OP2: R2←R2*R3
    - OP3: R1←R1+R2
  - Mode 3: registers load zero; OP1–OP3 perform no operation.
- Transitions into DONE:
  - On the OP3→DONE edge, y←R1 and err←(mode==3).
  - DONE always returns to IDLE on the next edge.
- Arithmetic:
  - Unsigned throughout.
  - The adder and multiplier results are truncated to RW bits. By construction no legal result exceeds RW, so no overflow is possible.
- `start` outside IDLE (OP1..DONE): ignored; the operands and mode inputs are don't-care.
- Reset values (take effect at the first edge with reset=1):
  - State: IDLE.
  - R1..R3, y: 0.
  - busy, done, err: 0.
  - PS: 3'b000.
- Reset priority: reset takes priority over `start` and over any in-flight computation. A reset during OP1..DONE aborts the computation and produces no `done` pulse.

## Timing

- Edge 0 accepts `start`. PS then reads OP1, OP2 and OP3 after edges 0, 1 and 2.
- After edge 3 the state is DONE: `done`=1 and `y` is valid. Latency is 4 cycles from the accept edge to the `done` cycle.
- Throughput: one result per 5 cycles. If `start` is held high, the next accept happens at the edge that leaves IDLE, one cycle after DONE.
- `busy` is 1 in OP1, OP2, OP3 and DONE.
- `y` and `err` are registered outputs. They hold their values from DONE until the edge that accepts the next start, at which point both are cleared to 0.
- All outputs are registered, with no combinational path from input to output. NS and the datapath selects are internal combinational signals.

## Structure

- Shared package `fsmd_pkg`:
  - State encodings: IDLE=0, OP1=1, OP2=2, OP3=3, DONE=4.
  - Mode codes.
  - Mux select codes for R1/R2/R3 (hold, load operand, add, multiply).
- Sub-module `fsmd_sop_datapath`: R1..R3, the input muxes, one adder and one multiplier, plus per-register load enables and selects.
- The top level holds the control FSM, the mode latch, the `y`/`err` registers and the handshake logic.

## Test plan

- With WIDTH=4:
  - Mode 0, a=3 b=5 c=2 e=7: `done`=1 exactly 4 cycles after accept, y=70, err=0, busy=1 for 4 cycles.
  - Mode 1, a=c=d=15: y=900 (max case fits RW=10), no truncation.
  - Mode 2, a=b=c=d=15: y=450. Then mode 2 with a=2 b=3 c=4 d=5: y=26. Verify PS steps through 0,1,2,3,4,0.
  - `start` held high continuously:
    - Accepts occur every 5 cycles.
    - `start` pulses during OP1..DONE with changed operands do not alter y.
    - `y` clears to 0 on the edge that accepts the next start.
- Reset asserted in OP2: the next cycle shows PS=0, busy=0, y=0 and no `done` pulse. A fresh start then computes correctly.
- Mode 3 with arbitrary operands: `done`=1 and err=1 together, y=0. The next mode-0 run clears err.
